// File: rtl/heap_feeder.sv
// Front-end of the max-heap pipeline: buffers sketch candidates in a small FIFO,
// merges repeat updates to the tail address, and issues spaced ops (query first).
module heap_feeder #(
  parameter int CNT_SIZE   = 20,
  parameter int ADDR_SIZE  = 28,
  parameter int FIFO_DEPTH = 8,
  parameter int ISSUE_GAP  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cand_valid,
  output logic                          cand_ready,
  input  logic [CNT_SIZE-1:0]           cand_cnt,
  input  logic [ADDR_SIZE-1:0]          cand_addr,
  input  logic                          query_req,
  output logic                          query_ack,
  output logic                          heap_valid,
  output logic [CNT_SIZE-1:0]           heap_cnt,
  output logic [ADDR_SIZE-1:0]          heap_addr,
  output logic                          heap_query,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   coalesce_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  typedef enum logic {IDLE, GAP} state_e;
  typedef struct packed {
    logic [CNT_SIZE-1:0]  cnt;
    logic [ADDR_SIZE-1:0] addr;
  } ent_t;

  ent_t                 mem_q [FIFO_DEPTH];
  logic [PW-1:0]        rd_q, wr_q, tail;
  logic [CW-1:0]        count_q, count_d;
  logic [15:0]          coal_q;
  logic                 pend_q;
  state_e               state_q;
  logic [GW-1:0]        gap_q;
  logic                 heap_valid_q, heap_query_q, query_ack_q;
  logic [CNT_SIZE-1:0]  heap_cnt_q;
  logic [ADDR_SIZE-1:0] heap_addr_q;
  logic                 push, pop, coal, issue_qry;

  assign cand_ready = (count_q < CW'(FIFO_DEPTH));
  assign push       = cand_valid && cand_ready;
  assign issue_qry  = (state_q == IDLE) && pend_q;
  assign pop        = (state_q == IDLE) && !pend_q && (count_q != '0);
  assign tail       = wr_q - PW'(1);
  // A tail that leaves this cycle can't absorb the update; it becomes a new entry.
  assign coal       = push && (count_q != '0) && (mem_q[tail].addr == cand_addr)
                      && !(pop && (count_q == CW'(1)));

  always_comb begin
    count_d = count_q;
    if (push && !coal) count_d = count_d + CW'(1);
    if (pop)           count_d = count_d - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      coal_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (pop) rd_q <= rd_q + PW'(1);
      if (push && !coal) begin
        wr_q        <= wr_q + PW'(1);
        mem_q[wr_q] <= '{cnt: cand_cnt, addr: cand_addr};
      end
      if (coal) begin
        if (cand_cnt > mem_q[tail].cnt) mem_q[tail].cnt <= cand_cnt;
        if (coal_q != 16'hFFFF) coal_q <= coal_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gap_q        <= '0;
      pend_q       <= 1'b0;
      heap_valid_q <= 1'b0;
      heap_query_q <= 1'b0;
      query_ack_q  <= 1'b0;
      heap_cnt_q   <= '0;
      heap_addr_q  <= '0;
    end else begin
      heap_valid_q <= 1'b0;
      heap_query_q <= 1'b0;
      query_ack_q  <= 1'b0;
      // Requests arriving while one is pending merge into it.
      pend_q <= issue_qry ? 1'b0 : (pend_q || query_req);
      case (state_q)
        IDLE: if (issue_qry || pop) begin
          heap_valid_q <= 1'b1;
          heap_query_q <= issue_qry;
          query_ack_q  <= issue_qry;
          heap_cnt_q   <= issue_qry ? '0 : mem_q[rd_q].cnt;
          heap_addr_q  <= issue_qry ? '0 : mem_q[rd_q].addr;
          if (ISSUE_GAP > 1) begin
            state_q <= GAP;
            gap_q   <= GW'(ISSUE_GAP - 1);
          end
        end
        GAP: begin
          gap_q <= gap_q - GW'(1);
          if (gap_q == GW'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign heap_valid   = heap_valid_q;
  assign heap_query   = heap_query_q;
  assign query_ack    = query_ack_q;
  assign heap_cnt     = heap_cnt_q;
  assign heap_addr    = heap_addr_q;
  assign fifo_count   = count_q;
  assign coalesce_cnt = coal_q;
endmodule

// File: tb/tb_heap_feeder.sv
// Scoreboard bench for heap_feeder: a queue-level reference model predicts every
// heap issue (cycle, kind, payload); a negedge monitor pops and compares.
module tb_heap_feeder;
  localparam int CW = 20, AW = 28, D = 8, GAP = 2;

  logic clk, rst, cand_valid, cand_ready, query_req, query_ack;
  logic heap_valid, heap_query;
  logic [CW-1:0] cand_cnt, heap_cnt;
  logic [AW-1:0] cand_addr, heap_addr;
  logic [$clog2(D):0] fifo_count;
  logic [15:0] coalesce_cnt;

  heap_feeder #(.CNT_SIZE(CW), .ADDR_SIZE(AW), .FIFO_DEPTH(D), .ISSUE_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .cand_valid(cand_valid), .cand_ready(cand_ready),
    .cand_cnt(cand_cnt), .cand_addr(cand_addr), .query_req(query_req),
    .query_ack(query_ack), .heap_valid(heap_valid), .heap_cnt(heap_cnt),
    .heap_addr(heap_addr), .heap_query(heap_query), .fifo_count(fifo_count),
    .coalesce_cnt(coalesce_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [CW-1:0] cnt; logic [AW-1:0] addr; } ent_t;
  typedef struct { int cyc; bit q; logic [CW-1:0] cnt; logic [AW-1:0] addr; } exp_t;

  int checks = 0, fails = 0;
  int dc = 0, mc = 0;
  ent_t mq[$];
  exp_t sb[$];
  bit m_pend, m_acc;
  int m_next_ok, m_coal, max_fc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (edge %0d)", nm, act, exp, dc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pend = 0; m_next_ok = 0; m_coal = 0; m_acc = 0;
  endtask

  // One clock edge of the reference: issue choice, then FIFO update.
  task automatic model_edge();
    bit acc, popped, qiss;
    exp_t e;
    acc = cand_valid && (mq.size() < D);
    popped = 0; qiss = 0;
    if (dc >= m_next_ok) begin
      if (m_pend) begin
        qiss = 1; e.cyc = dc; e.q = 1; e.cnt = '0; e.addr = '0;
        sb.push_back(e); m_next_ok = dc + GAP;
      end else if (mq.size() > 0) begin
        popped = 1; e.cyc = dc; e.q = 0; e.cnt = mq[0].cnt; e.addr = mq[0].addr;
        sb.push_back(e); m_next_ok = dc + GAP;
      end
    end
    if (acc && mq.size() > 0 && mq[mq.size()-1].addr == cand_addr &&
        !(popped && mq.size() == 1)) begin
      if (cand_cnt > mq[mq.size()-1].cnt) mq[mq.size()-1].cnt = cand_cnt;
      if (m_coal < 65535) m_coal++;
      if (popped) void'(mq.pop_front());
    end else begin
      if (popped) void'(mq.pop_front());
      if (acc) mq.push_back('{cnt: cand_cnt, addr: cand_addr});
    end
    m_pend = qiss ? 1'b0 : (m_pend || query_req);
    m_acc = acc;
  endtask

  task automatic tick();
    @(posedge clk);
    dc++;
    if (rst) model_reset(); else model_edge();
    #1;
    if (!rst) begin
      chk("fifo_count", fifo_count, mq.size());
      chk("coalesce_cnt", coalesce_cnt, m_coal);
      chk("cand_ready", cand_ready, mq.size() < D);
      if (int'(fifo_count) > max_fc) max_fc = fifo_count;
    end
  endtask

  // Present a candidate and hold it until the handshake completes.
  task automatic send(input int c, input int a);
    int n = 0;
    cand_valid = 1; cand_cnt = CW'(c); cand_addr = AW'(a);
    do begin tick(); n++; end while (!m_acc && n < 50);
    if (!m_acc) begin
      checks++; fails++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted addr=%0h", a);
    end
  endtask

  task automatic idle(input int n);
    cand_valid = 0; query_req = 0;
    repeat (n) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_heap_valid"}, heap_valid, 0);
    chk({tag, "_heap_query"}, heap_query, 0);
    chk({tag, "_query_ack"}, query_ack, 0);
    chk({tag, "_heap_cnt"}, heap_cnt, 0);
    chk({tag, "_heap_addr"}, heap_addr, 0);
    chk({tag, "_fifo_count"}, fifo_count, 0);
    chk({tag, "_coalesce_cnt"}, coalesce_cnt, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1; cand_valid = 0; query_req = 0;
    model_reset();
    #1 chk_zero("async_rst");
    tick(); tick();
    rst = 0;
  endtask

  // Monitor: compare each heap issue against the oldest prediction.
  int last_mc = -100;
  logic [CW-1:0] last_cnt = '0;
  logic [AW-1:0] last_addr = '0;
  always @(negedge clk) begin
    exp_t e;
    mc++;
    if (rst) begin
      last_mc = -100; last_cnt = '0; last_addr = '0;
    end else if (heap_valid) begin
      chk("ack_implies_query", query_ack, heap_query);
      chk("issue_gap_ok", (mc - last_mc) >= GAP, 1);
      last_mc = mc;
      if (sb.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_issue actual=valid expected=none cnt=%0h addr=%0h", heap_cnt, heap_addr);
      end else begin
        e = sb.pop_front();
        chk("issue_cycle", mc, e.cyc);
        chk("issue_query", heap_query, e.q);
        chk("issue_ack", query_ack, e.q);
        chk("issue_cnt", heap_cnt, e.cnt);
        chk("issue_addr", heap_addr, e.addr);
        last_cnt = e.cnt; last_addr = e.addr;
      end
    end else begin
      if (sb.size() > 0 && sb[0].cyc <= mc) begin
        e = sb.pop_front();
        checks++; fails++;
        $display("FAIL missing_issue actual=idle expected=issue cyc=%0d addr=%0h", e.cyc, e.addr);
      end
      if (query_ack) begin
        checks++; fails++;
        $display("FAIL ack_without_valid actual=1 expected=0");
      end
      chk("hold_cnt", heap_cnt, last_cnt);
      chk("hold_addr", heap_addr, last_addr);
    end
  end

  initial begin
    rst = 1; cand_valid = 0; cand_cnt = '0; cand_addr = '0; query_req = 0;
    max_fc = 0;
    model_reset();
    #2 chk_zero("reset");
    tick(); tick();
    rst = 0;
    idle(2);

    // Single candidate, then three back-to-back.
    send(5, 'h10); idle(4);
    send(1, 'h1); send(2, 'h2); send(3, 'h3); idle(8);

    // Repeat updates to the same address behind another entry.
    send(1, 'h30); send(2, 'h31); send(7, 'h20); send(4, 'h20); send(9, 'h20); idle(10);

    // Overfill: pushes every cycle outpace pops, so ready must drop.
    for (int i = 0; i < 16; i++) send(i + 100, 'h200 + i);
    idle(30);
    chk("fifo_filled", max_fc, D);

    // Query behind queued inserts, with a merged second pulse.
    send(11, 'h41); send(12, 'h42); send(13, 'h43);
    cand_valid = 0; query_req = 1; tick(); query_req = 0; tick();
    query_req = 1; tick(); query_req = 0;
    idle(12);

    // Reset with entries buffered and a query pending.
    for (int i = 0; i < 8; i++) send(i + 1, 'h500 + i);
    cand_valid = 0; query_req = 1; tick(); query_req = 0;
    do_reset();
    idle(10);

    // Randomized traffic over a narrow address set to provoke coalescing.
    cand_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (!(cand_valid && !m_acc)) begin
        cand_valid = ($urandom_range(0, 9) < 6);
        cand_cnt   = CW'($urandom_range(0, 1000));
        cand_addr  = AW'($urandom_range(0, 3));
      end
      query_req = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle(40);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
